cascade_count_ctrl: RTL and testbench

//   Sequencer for a two-stage cascaded counter pair on one clock domain: stage A counts up,

---
 rtl/cascade_cnt_pkg.sv | 14 +
 rtl/cnt_stage.sv | 24 ++
 rtl/cascade_count_ctrl.sv | 91 +++++++++
 tb/tb_cascade_count_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_cnt_pkg.sv
// Shared types for the cascaded counter sequencer.
// State encoding is visible on the state output port.
package cascade_cnt_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/cnt_stage.sv
// Loadable up/down counter stage with synchronous enable.
// load has priority over en.
module cnt_stage #(
  parameter int unsigned          WIDTH    = 4,
  parameter bit                   DIR      = 1'b1,
  parameter logic [WIDTH-1:0]     LOAD_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= LOAD_VAL;
    else if (load)
      q <= LOAD_VAL;
    else if (en)
      q <= DIR ? q + 1'b1 : q - 1'b1;
  end

endmodule

// File: rtl/cascade_count_ctrl.sv
// Start/pause/clear sequencer for an up-counter A feeding
// a down-counter B through a synchronous step enable.
module cascade_count_ctrl
  import cascade_cnt_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] A_TICK_MASK = 4'b0011,
  parameter logic [WIDTH-1:0] B_INIT      = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt_a,
  output logic [WIDTH-1:0] cnt_b,
  output logic             b_step,
  output logic             busy,
  output logic             done,
  output logic [ST_W-1:0]  state
);

  localparam logic [WIDTH-1:0] B_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t st, st_nx;
  logic   go, tick, run_en, restart;
  logic   load_cnt;

  assign go      = start & ~stop;
  assign tick    = (cnt_a & A_TICK_MASK) == A_TICK_MASK;
  assign run_en  = (st == ST_RUN) & ~stop & ~clear;
  assign b_step  = run_en & tick;
  assign restart = (st == ST_DONE) & go & ~clear;
  assign load_cnt = clear | restart;

  always_comb begin
    st_nx = st;
    if (clear) begin
      st_nx = ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE:  if (go) st_nx = ST_RUN;
        ST_RUN: begin
          if (stop)
            st_nx = ST_PAUSE;
          else if (b_step && cnt_b == B_ONE)
            st_nx = ST_DONE;
        end
        ST_PAUSE: if (go) st_nx = ST_RUN;
        ST_DONE:  if (go) st_nx = ST_RUN;
        default:  st_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      st <= ST_IDLE;
    else
      st <= st_nx;
  end

  cnt_stage #(
    .WIDTH    (WIDTH),
    .DIR      (1'b1),
    .LOAD_VAL ('0)
  ) u_a (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .load  (load_cnt),
    .q     (cnt_a)
  );

  cnt_stage #(
    .WIDTH    (WIDTH),
    .DIR      (1'b0),
    .LOAD_VAL (B_INIT)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .en    (b_step),
    .load  (load_cnt),
    .q     (cnt_b)
  );

  assign state = st;
  assign busy  = (st == ST_RUN) | (st == ST_PAUSE);
  assign done  = (st == ST_DONE);

endmodule

// File: tb/tb_cascade_count_ctrl.sv
// Self-checking bench for cascade_count_ctrl: table vectors,
// a reference model with an expectation queue, and corner sequences.
module tb_cascade_count_ctrl;

  logic       clk = 1'b0;
  logic       reset, clear, start, stop;
  logic [3:0] cnt_a, cnt_b;
  logic       b_step, busy, done;
  logic [1:0] state;

  logic       clear2, start2, stop2;
  logic [3:0] cnt_a2, cnt_b2;
  logic       b_step2, busy2, done2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cascade_count_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .b_step(b_step), .busy(busy),
    .done(done), .state(state)
  );

  cascade_count_ctrl #(
    .WIDTH(4), .A_TICK_MASK(4'b0000), .B_INIT(4'h2)
  ) dut2 (
    .clk(clk), .reset(reset), .clear(clear2), .start(start2), .stop(stop2),
    .cnt_a(cnt_a2), .cnt_b(cnt_b2), .b_step(b_step2), .busy(busy2),
    .done(done2), .state(state2)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  typedef struct {
    logic       s, p, c;
    logic       bs;
    logic [1:0] st;
    logic [3:0] a, b;
  } vec_t;

  exp_t       sbq[$];
  logic [1:0] ms;
  logic [3:0] ma, mb;
  logic       last_bs;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 2'b00;
    ma = 4'h0;
    mb = 4'hF;
    sbq.delete();
  endtask

  // One clock: drive at negedge, check comb b_step, check state after edge
  task automatic step(input logic s, input logic p, input logic c);
    logic mbs;
    exp_t e;
    @(negedge clk);
    start = s;
    stop  = p;
    clear = c;
    #1;
    mbs = (ms == 2'b01) && !p && !c && ((ma & 4'b0011) == 4'b0011);
    last_bs = b_step;
    chk("b_step", b_step, mbs);
    if (c) begin
      ms = 2'b00; ma = 4'h0; mb = 4'hF;
    end else begin
      case (ms)
        2'b00: if (s && !p) ms = 2'b01;
        2'b01: begin
          if (p) ms = 2'b10;
          else begin
            ma = ma + 4'h1;
            if (mbs) begin
              if (mb == 4'h1) ms = 2'b11;
              mb = mb - 4'h1;
            end
          end
        end
        2'b10: if (s && !p) ms = 2'b01;
        default: if (s && !p) begin
          ms = 2'b01; ma = 4'h0; mb = 4'hF;
        end
      endcase
    end
    sbq.push_back('{st: ms, a: ma, b: mb});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_state", {state, cnt_a, cnt_b}, {e.st, e.a, e.b});
      chk("sb_flags", {busy, done}, {(e.st == 2'b01 || e.st == 2'b10),
                                     (e.st == 2'b11)});
    end
  endtask

  vec_t vt[10];

  initial begin
    reset = 1'b1; clear = 0; start = 0; stop = 0;
    clear2 = 0; start2 = 0; stop2 = 0;
    model_reset();
    #12;
    chk("rst_out", {state, cnt_a, cnt_b, busy, done, b_step},
        {2'b00, 4'h0, 4'hF, 3'b000});
    @(negedge clk);
    reset = 1'b0;

    // s p c  bs  st    a     b
    vt[0] = '{1, 1, 0, 0, 2'b00, 4'h0, 4'hF};
    vt[1] = '{1, 0, 0, 0, 2'b01, 4'h0, 4'hF};
    vt[2] = '{0, 0, 0, 0, 2'b01, 4'h1, 4'hF};
    vt[3] = '{0, 0, 0, 0, 2'b01, 4'h2, 4'hF};
    vt[4] = '{0, 0, 0, 0, 2'b01, 4'h3, 4'hF};
    vt[5] = '{1, 1, 0, 0, 2'b10, 4'h3, 4'hF};
    vt[6] = '{0, 1, 0, 0, 2'b10, 4'h3, 4'hF};
    vt[7] = '{1, 0, 0, 0, 2'b01, 4'h3, 4'hF};
    vt[8] = '{0, 0, 0, 1, 2'b01, 4'h4, 4'hE};
    vt[9] = '{0, 0, 1, 0, 2'b00, 4'h0, 4'hF};
    for (int i = 0; i < 10; i++) begin
      step(vt[i].s, vt[i].p, vt[i].c);
      chk($sformatf("vec%0d_bs", i), last_bs, vt[i].bs);
      chk($sformatf("vec%0d", i), {state, cnt_a, cnt_b},
          {vt[i].st, vt[i].a, vt[i].b});
    end

    // Full run to terminal count
    step(1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0);
      if (i == 3)
        chk("first_dec", {last_bs, cnt_b}, {1'b1, 4'hE});
    end
    chk("done_at_60", {state, done, cnt_a, cnt_b}, {2'b11, 1'b1, 4'hC, 4'h0});
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("done_frozen", {state, cnt_a, cnt_b}, {2'b11, 4'hC, 4'h0});

    // Restart from DONE
    step(1, 0, 0);
    chk("restart", {state, cnt_a, cnt_b}, {2'b01, 4'h0, 4'hF});

    // Pause at 5, hold, resume
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(0, 1, 0);
    chk("pause_at5", {state, cnt_a}, {2'b10, 4'h5});
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("pause_hold", {state, cnt_a, cnt_b}, {2'b10, 4'h5, 4'hE});
    step(1, 0, 0);
    chk("resume", {state, cnt_a}, {2'b01, 4'h5});
    step(0, 0, 0);
    chk("resume6", cnt_a, 4'h6);
    step(0, 0, 0);
    chk("resume7", cnt_a, 4'h7);

    // Clear in PAUSE
    step(0, 1, 0);
    step(1, 0, 1);
    chk("clear_pause", {state, cnt_a, cnt_b, busy}, {2'b00, 4'h0, 4'hF, 1'b0});

    // Async reset mid-RUN
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_midrun", {state, cnt_a, cnt_b, busy, done},
        {2'b00, 4'h0, 4'hF, 2'b00});
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0);

    // Mask 0, B_INIT 2
    @(negedge clk);
    start2 = 1'b1;
    #1;
    chk("m0_idle_bs", b_step2, 1'b0);
    @(posedge clk); #1;
    chk("m0_run", {state2, cnt_a2, cnt_b2}, {2'b01, 4'h0, 4'h2});
    @(negedge clk);
    start2 = 1'b0;
    #1;
    chk("m0_bs1", b_step2, 1'b1);
    @(posedge clk); #1;
    chk("m0_c1", {state2, cnt_a2, cnt_b2}, {2'b01, 4'h1, 4'h1});
    @(negedge clk);
    #1;
    chk("m0_bs2", b_step2, 1'b1);
    @(posedge clk); #1;
    chk("m0_done", {state2, done2, cnt_a2, cnt_b2}, {2'b11, 1'b1, 4'h2, 4'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
